cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result-writeback arbiter between the execution units and the reorder buffer. The ALU and the load/store buffer each produce at most one result per cycle. The arbiter merges them onto a single registered common data bus (CDB), using per-source FIFOs and round-robin priority. The CDB feeds the ROB ready/result write port and the reservation-station and LSB operand snoop. A branch-mispredict flush (`clr_in`) from the ROB discards all buffered results.

## Interface
Parameters:
- `DATA_W`, 32, result width.
- `ADDR_W`, 32, branch target width.
- `ROB_IDX_W`, 4, ROB index width.
- `FIFO_DEPTH`, 4, entries per source FIFO (power of two, ≥2).

Ports:
- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global ready; low freezes all state.
- `clr_in`  in  1  flush from ROB; synchronous.
- `alu_ready`  in  1  ALU result valid.
- `alu_result`  in  DATA_W  ALU result value.
- `alu_rob_index`  in  ROB_IDX_W  ROB entry the ALU result belongs to.
- `alu_branch`  in  1  actual branch outcome.
- `alu_newPC`  in  ADDR_W  branch/jump target.
- `alu_full`  out  1  ALU FIFO full; the ALU must not assert `alu_ready` while this is high.
- `lsb_ready`  in  1  LSB result valid.
- `lsb_result`  in  DATA_W  LSB result value.
- `lsb_rob_index`  in  ROB_IDX_W  ROB entry the LSB result belongs to.
- `lsb_full`  out  1  LSB FIFO full.
- `cdb_valid`  out  1  CDB carries a result this cycle.
- `cdb_rob_index`  out  ROB_IDX_W  ROB entry being written.
- `cdb_result`  out  DATA_W  result value.
- `cdb_branch`  out  1  branch outcome; 0 for LSB results.
- `cdb_newPC`  out  ADDR_W  branch target; 0 for LSB results.
- `cdb_src`  out  1  0 = ALU, 1 = LSB.
- `overflow`  out  1  sticky error flag: a push arrived while full.

## Operation
- Each source owns a FIFO: `FIFO_DEPTH` entries, read/write pointers, and a count of width clog2(DEPTH)+1. ALU entries hold {index, result, branch, newPC}; LSB entries hold {index, result}.
- A source is a candidate when its FIFO is non-empty or its `*_ready` input is high.
- A candidate's head entry is the FIFO head if the FIFO is non-empty. Otherwise it is the live input (bypass).
- Per-source ordering is strict FIFO: a live input never overtakes buffered entries of the same source.
- Grant rule, one grant per cycle:
  - only one candidate: grant it;
  - both candidates: grant the source not equal to `last_grant`;
  - `last_grant` updates to the granted source on every grant.
- Granted head is registered onto the CDB. `cdb_valid` is 1 on the next cycle; otherwise `cdb_valid` is 0 and the other CDB fields hold their values.
- Push/pop per source:
  - valid input not consumed by bypass → push;
  - granted and FIFO non-empty → pop;
  - push and pop in the same cycle → count unchanged.
- `*_full` is high when count == `FIFO_DEPTH`. It is combinational from count and does not account for a same-cycle pop.
- Push while full: input dropped, FIFO unchanged, `overflow` set until reset.
- Pointers wrap modulo `FIFO_DEPTH`.
- `clr_in` high, with `rdy_in` high: both FIFOs emptied, that cycle's inputs discarded, `cdb_valid` cleared to 0 next cycle, `last_grant` set to LSB. `overflow` is retained.
- `rdy_in` low: no push, pop, grant or flush; inputs ignored; all registers hold. `cdb_valid` holds, so a consumer must also qualify it with `rdy_in`.

## Timing
- Reset (`rst_in` = 0, asynchronous):
  - `cdb_valid`, `cdb_rob_index`, `cdb_result`, `cdb_branch`, `cdb_newPC`, `cdb_src`, `overflow` = 0;
  - FIFOs empty, so `alu_full` = `lsb_full` = 0;
  - `last_grant` = LSB, so the ALU wins the first contention.
- Reset asserted mid-operation drops all buffered entries immediately.
- Latency:
  - empty FIFO, input granted in cycle N → on the CDB in cycle N+1;
  - each buffered entry adds one cycle per grant it waits.
- Throughput: one result per cycle. Under continuous contention, grants alternate ALU/LSB.
- `clr_in` priority: `rst_in` > `clr_in` > normal operation.

## Test plan
- Single ALU push {idx 3, result 0x55, branch 1, newPC 0x100} in cycle 0 → cycle 1: `cdb_valid` = 1, idx 3, result 0x55, branch 1, newPC 0x100, src 0; cycle 2: `cdb_valid` = 0.
- ALU idx 1 and LSB idx 2 both valid in cycle 0 after reset → cycle 1: ALU idx 1; cycle 2: LSB idx 2.
- ALU and LSB valid every cycle for 8 cycles with indices 1..8 / 9..15,1 → CDB alternates ALU/LSB; per-source order preserved; `alu_full` asserts once the ALU count reaches 4; no `overflow`.
- Fill LSB FIFO to 4 while the ALU wins, then push once more with `lsb_full` = 1 → `overflow` = 1; the fifth entry never appears on the CDB.
- 3 entries buffered per source, `clr_in` pulsed for 1 cycle → next cycle `cdb_valid` = 0, `alu_full` = `lsb_full` = 0; a subsequent push of LSB idx 7 appears after 1 cycle.
- `rdy_in` low for 3 cycles with 2 ALU entries buffered → CDB outputs and count frozen; resumes in order when `rdy_in` returns high. `rst_in` low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//
// Purpose: groups the result-writeback traffic of the CDB arbiter into one
// bundle. It carries the ALU and LSB result producers, their FIFO-full
// back-pressure, the registered common data bus and the sticky overflow flag.
//
// Modports:
//   master - producer/consumer side (execution units, ROB, testbench):
//            drives the alu_* and lsb_* result inputs and observes the full
//            flags, the CDB fields and overflow.
//   slave  - the arbiter itself: the mirror image of master.
//
// Signals:
//   alu_ready/alu_result/alu_rob_index/alu_branch/alu_newPC  ALU result
//   alu_full                                                 ALU FIFO full
//   lsb_ready/lsb_result/lsb_rob_index                       LSB result
//   lsb_full                                                 LSB FIFO full
//   cdb_valid/cdb_rob_index/cdb_result/cdb_branch/cdb_newPC/cdb_src  CDB
//   overflow                                                 sticky error
interface cdb_arbiter_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ROB_IDX_W = 4
);
  logic                 alu_ready;
  logic [DATA_W-1:0]    alu_result;
  logic [ROB_IDX_W-1:0] alu_rob_index;
  logic                 alu_branch;
  logic [ADDR_W-1:0]    alu_newPC;
  logic                 alu_full;

  logic                 lsb_ready;
  logic [DATA_W-1:0]    lsb_result;
  logic [ROB_IDX_W-1:0] lsb_rob_index;
  logic                 lsb_full;

  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_index;
  logic [DATA_W-1:0]    cdb_result;
  logic                 cdb_branch;
  logic [ADDR_W-1:0]    cdb_newPC;
  logic                 cdb_src;
  logic                 overflow;

  modport master (
    output alu_ready, alu_result, alu_rob_index, alu_branch, alu_newPC,
    output lsb_ready, lsb_result, lsb_rob_index,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_rob_index, cdb_result, cdb_branch, cdb_newPC, cdb_src,
    input  overflow
  );

  modport slave (
    input  alu_ready, alu_result, alu_rob_index, alu_branch, alu_newPC,
    input  lsb_ready, lsb_result, lsb_rob_index,
    output alu_full, lsb_full,
    output cdb_valid, cdb_rob_index, cdb_result, cdb_branch, cdb_newPC, cdb_src,
    output overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//
// Purpose: merges ALU and load/store-buffer results onto a single registered
// common data bus. Each source owns a small FIFO; when both sources have a
// result, grants alternate (round robin on the last granted source). A live
// input with an empty FIFO bypasses straight to the CDB register. A flush
// from the ROB empties both FIFOs.
//
// Ports:
//   clk_in  - clock, rising edge
//   rst_in  - asynchronous active-low reset
//   rdy_in  - global ready; low freezes every register and ignores inputs
//   clr_in  - synchronous flush (mispredict) from the ROB
//   bus     - cdb_arbiter_if.slave: source results, full flags, CDB, overflow
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ROB_IDX_W  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          clr_in,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    result;
    logic                 branch;
    logic [ADDR_W-1:0]    new_pc;
  } alu_entry_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    result;
  } lsb_entry_t;

  alu_entry_t alu_mem_q [FIFO_DEPTH];
  lsb_entry_t lsb_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_rd_ptr_q, alu_rd_ptr_d, alu_wr_ptr_q, alu_wr_ptr_d;
  logic [PTR_W-1:0] lsb_rd_ptr_q, lsb_rd_ptr_d, lsb_wr_ptr_q, lsb_wr_ptr_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  src_e             last_grant_q, last_grant_d;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0] cdb_idx_q, cdb_idx_d;
  logic [DATA_W-1:0]    cdb_result_q, cdb_result_d;
  logic                 cdb_branch_q, cdb_branch_d;
  logic [ADDR_W-1:0]    cdb_pc_q, cdb_pc_d;
  src_e                 cdb_src_q, cdb_src_d;
  logic                 overflow_q, overflow_d;

  logic       active;
  logic       alu_empty, lsb_empty, alu_full, lsb_full;
  logic       alu_cand, lsb_cand, grant_alu, grant_lsb;
  logic       alu_push_req, lsb_push_req;
  logic       alu_push, lsb_push, alu_pop, lsb_pop, alu_drop, lsb_drop;
  alu_entry_t alu_live, alu_head;
  lsb_entry_t lsb_live, lsb_head;

  // Occupancy flags. Full ignores a same-cycle pop on purpose, so the
  // producer sees a stable, purely registered back-pressure signal.
  assign active    = rdy_in && !clr_in;
  assign alu_empty = (alu_cnt_q == '0);
  assign lsb_empty = (lsb_cnt_q == '0);
  assign alu_full  = (alu_cnt_q == FULL_CNT);
  assign lsb_full  = (lsb_cnt_q == FULL_CNT);

  // Head selection: buffered entries always go first, the live input only
  // bypasses when its FIFO is empty, which keeps per-source order strict.
  always_comb begin
    alu_live.idx    = bus.alu_rob_index;
    alu_live.result = bus.alu_result;
    alu_live.branch = bus.alu_branch;
    alu_live.new_pc = bus.alu_newPC;
    lsb_live.idx    = bus.lsb_rob_index;
    lsb_live.result = bus.lsb_result;
    alu_head = alu_empty ? alu_live : alu_mem_q[alu_rd_ptr_q];
    lsb_head = lsb_empty ? lsb_live : lsb_mem_q[lsb_rd_ptr_q];
  end

  // Round-robin grant: on contention the source that did not win last time
  // gets the bus. A live input granted through bypass is not pushed.
  assign alu_cand     = active && (!alu_empty || bus.alu_ready);
  assign lsb_cand     = active && (!lsb_empty || bus.lsb_ready);
  assign grant_alu    = alu_cand && (!lsb_cand || (last_grant_q == SRC_LSB));
  assign grant_lsb    = lsb_cand && !grant_alu;

  assign alu_push_req = active && bus.alu_ready && !(grant_alu && alu_empty);
  assign lsb_push_req = active && bus.lsb_ready && !(grant_lsb && lsb_empty);
  assign alu_push     = alu_push_req && !alu_full;
  assign lsb_push     = lsb_push_req && !lsb_full;
  assign alu_drop     = alu_push_req && alu_full;
  assign lsb_drop     = lsb_push_req && lsb_full;
  assign alu_pop      = grant_alu && !alu_empty;
  assign lsb_pop      = grant_lsb && !lsb_empty;

  // Next-state logic. A flush only takes effect while rdy_in is high; all
  // other updates are already gated through 'active'.
  always_comb begin
    alu_rd_ptr_d = alu_rd_ptr_q;
    alu_wr_ptr_d = alu_wr_ptr_q;
    lsb_rd_ptr_d = lsb_rd_ptr_q;
    lsb_wr_ptr_d = lsb_wr_ptr_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_cnt_d    = lsb_cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_idx_d    = cdb_idx_q;
    cdb_result_d = cdb_result_q;
    cdb_branch_d = cdb_branch_q;
    cdb_pc_d     = cdb_pc_q;
    cdb_src_d    = cdb_src_q;
    overflow_d   = overflow_q;

    if (rdy_in && clr_in) begin
      alu_rd_ptr_d = '0;
      alu_wr_ptr_d = '0;
      lsb_rd_ptr_d = '0;
      lsb_wr_ptr_d = '0;
      alu_cnt_d    = '0;
      lsb_cnt_d    = '0;
      cdb_valid_d  = 1'b0;
      last_grant_d = SRC_LSB;
    end else if (rdy_in) begin
      if (alu_push) alu_wr_ptr_d = alu_wr_ptr_q + PTR_W'(1);
      if (alu_pop)  alu_rd_ptr_d = alu_rd_ptr_q + PTR_W'(1);
      if (lsb_push) lsb_wr_ptr_d = lsb_wr_ptr_q + PTR_W'(1);
      if (lsb_pop)  lsb_rd_ptr_d = lsb_rd_ptr_q + PTR_W'(1);

      if (alu_push && !alu_pop)      alu_cnt_d = alu_cnt_q + CNT_W'(1);
      else if (!alu_push && alu_pop) alu_cnt_d = alu_cnt_q - CNT_W'(1);
      if (lsb_push && !lsb_pop)      lsb_cnt_d = lsb_cnt_q + CNT_W'(1);
      else if (!lsb_push && lsb_pop) lsb_cnt_d = lsb_cnt_q - CNT_W'(1);

      cdb_valid_d = grant_alu || grant_lsb;
      if (grant_alu) begin
        cdb_idx_d    = alu_head.idx;
        cdb_result_d = alu_head.result;
        cdb_branch_d = alu_head.branch;
        cdb_pc_d     = alu_head.new_pc;
        cdb_src_d    = SRC_ALU;
        last_grant_d = SRC_ALU;
      end else if (grant_lsb) begin
        cdb_idx_d    = lsb_head.idx;
        cdb_result_d = lsb_head.result;
        cdb_branch_d = 1'b0;
        cdb_pc_d     = '0;
        cdb_src_d    = SRC_LSB;
        last_grant_d = SRC_LSB;
      end

      overflow_d = overflow_q || alu_drop || lsb_drop;
    end
  end

  // Control and CDB registers. Reset leaves last_grant at LSB so the ALU
  // wins the first contention.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_rd_ptr_q <= '0;
      alu_wr_ptr_q <= '0;
      lsb_rd_ptr_q <= '0;
      lsb_wr_ptr_q <= '0;
      alu_cnt_q    <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_idx_q    <= '0;
      cdb_result_q <= '0;
      cdb_branch_q <= 1'b0;
      cdb_pc_q     <= '0;
      cdb_src_q    <= SRC_ALU;
      overflow_q   <= 1'b0;
    end else begin
      alu_rd_ptr_q <= alu_rd_ptr_d;
      alu_wr_ptr_q <= alu_wr_ptr_d;
      lsb_rd_ptr_q <= lsb_rd_ptr_d;
      lsb_wr_ptr_q <= lsb_wr_ptr_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_idx_q    <= cdb_idx_d;
      cdb_result_q <= cdb_result_d;
      cdb_branch_q <= cdb_branch_d;
      cdb_pc_q     <= cdb_pc_d;
      cdb_src_q    <= cdb_src_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage needs no reset: the counts decide which slots are live.
  always_ff @(posedge clk_in) begin
    if (alu_push) alu_mem_q[alu_wr_ptr_q] <= alu_live;
    if (lsb_push) lsb_mem_q[lsb_wr_ptr_q] <= lsb_live;
  end

  assign bus.alu_full      = alu_full;
  assign bus.lsb_full      = lsb_full;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_rob_index = cdb_idx_q;
  assign bus.cdb_result    = cdb_result_q;
  assign bus.cdb_branch    = cdb_branch_q;
  assign bus.cdb_newPC     = cdb_pc_q;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//
// Purpose: directed testbench for cdb_arbiter. Each scenario task drives its
// own stimulus and compares the CDB against hand-derived values. A monitor
// records every newly registered CDB result so whole streams can be checked
// for order and alternation.
module tb_cdb_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int ROB_IDX_W  = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic        src;
    logic [3:0]  idx;
    logic [31:0] res;
    logic        br;
    logic [31:0] pc;
  } rec_t;

  logic clk;
  logic rstN;
  logic rdy;
  logic clr;
  int   checks;
  int   errors;
  logic edgeLive;
  rec_t got[$];

  cdb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_IDX_W(ROB_IDX_W)) bus ();

  cdb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_IDX_W(ROB_IDX_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_in(clk),
    .rst_in(rstN),
    .rdy_in(rdy),
    .clr_in(clr),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remember whether the last rising edge could update the CDB register.
  always @(posedge clk) edgeLive = rdy && rstN;

  // Record each freshly registered CDB result in the middle of the cycle.
  always @(negedge clk) begin
    rec_t r;
    if (edgeLive && bus.cdb_valid) begin
      r.src = bus.cdb_src;
      r.idx = bus.cdb_rob_index;
      r.res = bus.cdb_result;
      r.br  = bus.cdb_branch;
      r.pc  = bus.cdb_newPC;
      got.push_back(r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_ready     = 1'b0;
    bus.alu_result    = '0;
    bus.alu_rob_index = '0;
    bus.alu_branch    = 1'b0;
    bus.alu_newPC     = '0;
    bus.lsb_ready     = 1'b0;
    bus.lsb_result    = '0;
    bus.lsb_rob_index = '0;
  endtask

  // ALU results are encoded from the index: result A000+idx, branch idx[0], newPC idx*4.
  task automatic driveAlu(input logic [3:0] idx);
    bus.alu_ready     = 1'b1;
    bus.alu_rob_index = idx;
    bus.alu_result    = 32'hA000 + {28'b0, idx};
    bus.alu_branch    = idx[0];
    bus.alu_newPC     = {26'b0, idx, 2'b00};
  endtask

  // LSB results: result B000+idx.
  task automatic driveLsb(input logic [3:0] idx);
    bus.lsb_ready     = 1'b1;
    bus.lsb_rob_index = idx;
    bus.lsb_result    = 32'hB000 + {28'b0, idx};
  endtask

  task automatic resetDut();
    idle();
    rdy  = 1'b1;
    clr  = 1'b0;
    rstN = 1'b0;
    repeat (2) tick();
    rstN = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    idle();
    rdy  = 1'b1;
    clr  = 1'b0;
    rstN = 1'b0;
    #3;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.cdb_valid); end
    checks++;
    if ({bus.cdb_rob_index, bus.cdb_result, bus.cdb_branch, bus.cdb_newPC, bus.cdb_src} !== '0) begin
      errors++; $display("[TB] FAIL reset_cdb_fields: got idx %0h res %0h br %0b pc %0h src %0b expected all 0",
                         bus.cdb_rob_index, bus.cdb_result, bus.cdb_branch, bus.cdb_newPC, bus.cdb_src);
    end
    checks++;
    if ({bus.alu_full, bus.lsb_full, bus.overflow} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got full %0b/%0b ovf %0b expected 0/0/0", bus.alu_full, bus.lsb_full, bus.overflow);
    end
    resetDut();
  endtask

  task automatic test_single_alu();
    resetDut();
    driveAlu(4'd3);
    bus.alu_result = 32'h55;
    bus.alu_branch = 1'b1;
    bus.alu_newPC  = 32'h100;
    tick();
    idle();
    checks++;
    if ({bus.cdb_valid, bus.cdb_src} !== 2'b10) begin errors++; $display("[TB] FAIL single_valid_src: got %0b%0b expected 10", bus.cdb_valid, bus.cdb_src); end
    checks++;
    if (bus.cdb_rob_index !== 4'd3 || bus.cdb_result !== 32'h55) begin
      errors++; $display("[TB] FAIL single_idx_res: got %0h/%0h expected 3/55", bus.cdb_rob_index, bus.cdb_result);
    end
    checks++;
    if (bus.cdb_branch !== 1'b1 || bus.cdb_newPC !== 32'h100) begin
      errors++; $display("[TB] FAIL single_br_pc: got %0b/%0h expected 1/100", bus.cdb_branch, bus.cdb_newPC);
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drop_valid: got %0b expected 0", bus.cdb_valid); end
    checks++;
    if (bus.cdb_rob_index !== 4'd3) begin errors++; $display("[TB] FAIL single_hold_idx: got %0h expected 3", bus.cdb_rob_index); end
  endtask

  task automatic test_contention();
    resetDut();
    driveAlu(4'd1);
    driveLsb(4'd2);
    tick();
    idle();
    checks++;
    if ({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index} !== {1'b1, 1'b0, 4'd1}) begin
      errors++; $display("[TB] FAIL contend_first: got v%0b s%0b i%0h expected v1 s0 i1", bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index);
    end
    tick();
    checks++;
    if ({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index} !== {1'b1, 1'b1, 4'd2}) begin
      errors++; $display("[TB] FAIL contend_second: got v%0b s%0b i%0h expected v1 s1 i2", bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index);
    end
    checks++;
    if (bus.cdb_result !== 32'hB002 || bus.cdb_branch !== 1'b0 || bus.cdb_newPC !== 32'h0) begin
      errors++; $display("[TB] FAIL contend_lsb_fields: got %0h/%0b/%0h expected B002/0/0", bus.cdb_result, bus.cdb_branch, bus.cdb_newPC);
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL contend_idle: got %0b expected 0", bus.cdb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  lsbIdx [8];
    logic [3:0]  expIdx;
    logic        expSrc;
    logic [31:0] expRes;
    logic        expBr;
    logic [31:0] expPc;
    int          aNext;
    int          lNext;
    resetDut();
    for (int i = 0; i < 8; i++) lsbIdx[i] = (i == 7) ? 4'd1 : 4'(9 + i);
    aNext = 0;
    lNext = 0;
    for (int c = 0; c < 20 && (aNext < 8 || lNext < 8); c++) begin
      if (c == 7) begin
        checks++;
        if (bus.lsb_full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_lsb_full: got %0b expected 1", bus.lsb_full); end
      end
      if (c == 8) begin
        checks++;
        if (bus.alu_full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_alu_full: got %0b expected 1", bus.alu_full); end
      end
      idle();
      if (aNext < 8 && !bus.alu_full) begin driveAlu(4'(aNext + 1)); aNext++; end
      if (lNext < 8 && !bus.lsb_full) begin driveLsb(lsbIdx[lNext]); lNext++; end
      tick();
    end
    idle();
    repeat (20) tick();
    checks++;
    if (got.size() != 16) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 16", got.size()); end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      expSrc = k[0];
      expIdx = k[0] ? lsbIdx[k / 2] : 4'(k / 2 + 1);
      expRes = k[0] ? 32'hB000 + {28'b0, expIdx} : 32'hA000 + {28'b0, expIdx};
      expBr  = k[0] ? 1'b0 : expIdx[0];
      expPc  = k[0] ? 32'h0 : {26'b0, expIdx, 2'b00};
      checks++;
      if (got[k].src !== expSrc || got[k].idx !== expIdx || got[k].res !== expRes || got[k].br !== expBr || got[k].pc !== expPc) begin
        errors++; $display("[TB] FAIL b2b_entry%0d: got s%0b i%0h r%0h b%0b p%0h expected s%0b i%0h r%0h b%0b p%0h", k,
                           got[k].src, got[k].idx, got[k].res, got[k].br, got[k].pc, expSrc, expIdx, expRes, expBr, expPc);
      end
    end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow: got %0b expected 0", bus.overflow); end
  endtask

  task automatic test_overflow();
    logic [3:0] expIdx;
    logic       expSrc;
    resetDut();
    for (int c = 0; c < 7; c++) begin
      driveAlu(4'(c + 1));
      driveLsb(4'(c + 8));
      tick();
    end
    idle();
    checks++;
    if ({bus.lsb_full, bus.alu_full} !== 2'b10) begin
      errors++; $display("[TB] FAIL ovf_full_flags: got lsb %0b alu %0b expected 1/0", bus.lsb_full, bus.alu_full);
    end
    driveLsb(4'd15);
    tick();
    idle();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %0b expected 1", bus.overflow); end
    repeat (20) tick();
    checks++;
    if (got.size() != 14) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 14", got.size()); end
    for (int k = 0; k < 14 && k < got.size(); k++) begin
      expSrc = k[0];
      expIdx = k[0] ? 4'(8 + k / 2) : 4'(k / 2 + 1);
      checks++;
      if (got[k].src !== expSrc || got[k].idx !== expIdx) begin
        errors++; $display("[TB] FAIL ovf_entry%0d: got s%0b i%0h expected s%0b i%0h", k, got[k].src, got[k].idx, expSrc, expIdx);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_clr: got %0b expected 1", bus.overflow); end
  endtask

  task automatic test_flush();
    resetDut();
    for (int c = 0; c < 6; c++) begin
      driveAlu(4'(c + 1));
      driveLsb(4'(c + 9));
      tick();
    end
    clr = 1'b1;
    driveAlu(4'd12);
    driveLsb(4'd13);
    tick();
    clr = 1'b0;
    idle();
    checks++;
    if ({bus.cdb_valid, bus.alu_full, bus.lsb_full} !== 3'b000) begin
      errors++; $display("[TB] FAIL flush_state: got v%0b af%0b lf%0b expected 0/0/0", bus.cdb_valid, bus.alu_full, bus.lsb_full);
    end
    driveLsb(4'd7);
    tick();
    idle();
    checks++;
    if ({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index} !== {1'b1, 1'b1, 4'd7}) begin
      errors++; $display("[TB] FAIL flush_after_push: got v%0b s%0b i%0h expected v1 s1 i7", bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index);
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_leftover: got %0b expected 0", bus.cdb_valid); end
  endtask

  task automatic test_rdy_freeze();
    logic [3:0] expIdx;
    logic       expSrc;
    resetDut();
    for (int c = 0; c < 4; c++) begin
      driveAlu(4'(c + 1));
      driveLsb(4'(c + 5));
      tick();
    end
    rdy = 1'b0;
    driveAlu(4'd9);
    driveLsb(4'd10);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index, bus.alu_full} !== {1'b1, 1'b1, 4'd6, 1'b0}) begin
        errors++; $display("[TB] FAIL freeze_cycle%0d: got v%0b s%0b i%0h af%0b expected v1 s1 i6 af0", c,
                           bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index, bus.alu_full);
      end
    end
    idle();
    rdy = 1'b1;
    repeat (10) tick();
    checks++;
    if (got.size() != 8) begin errors++; $display("[TB] FAIL freeze_count: got %0d expected 8", got.size()); end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      expSrc = k[0];
      expIdx = k[0] ? 4'(5 + k / 2) : 4'(k / 2 + 1);
      checks++;
      if (got[k].src !== expSrc || got[k].idx !== expIdx) begin
        errors++; $display("[TB] FAIL freeze_entry%0d: got s%0b i%0h expected s%0b i%0h", k, got[k].src, got[k].idx, expSrc, expIdx);
      end
    end
  endtask

  task automatic test_async_reset();
    resetDut();
    for (int c = 0; c < 3; c++) begin
      driveAlu(4'(c + 1));
      driveLsb(4'(c + 5));
      tick();
    end
    idle();
    checks++;
    if (bus.cdb_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_valid: got %0b expected 1", bus.cdb_valid); end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_branch, bus.cdb_newPC, bus.cdb_src, bus.overflow} !== '0) begin
      errors++; $display("[TB] FAIL areset_outputs: got v%0b i%0h r%0h b%0b p%0h s%0b o%0b expected all 0", bus.cdb_valid,
                         bus.cdb_rob_index, bus.cdb_result, bus.cdb_branch, bus.cdb_newPC, bus.cdb_src, bus.overflow);
    end
    tick();
    rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_dropped%0d: got %0b expected 0", c, bus.cdb_valid); end
    end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    edgeLive = 1'b0;
    test_reset();
    test_single_alu();
    test_contention();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_rdy_freeze();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
